// File: rtl/jt12_wr_pkg.sv
// Shared definitions for the jt12 register-write scheduler: FSM states and
// the register numbers it treats specially.
package jt12_wr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    GAP,
    DATA,
    WAIT
  } wr_state_e;

  localparam logic [7:0] REG_PCM    = 8'h2A;
  localparam logic [7:0] REG_CLK_N6 = 8'h2D;
  localparam logic [7:0] REG_CLK_N3 = 8'h2E;
  localparam logic [7:0] REG_CLK_N2 = 8'h2F;

  // Prescaler writes must never be followed by a skipped address phase.
  function automatic logic is_prescaler(input logic [7:0] r);
    return (r == REG_CLK_N6) || (r == REG_CLK_N3) || (r == REG_CLK_N2);
  endfunction

endpackage

// File: rtl/jt12_wr_arb.sv
// Two-port arbiter: port 0 has priority, port 1 wins after STARVE
// consecutive port-0 grants taken while port 1 was waiting.
module jt12_wr_arb #(
  parameter int unsigned STARVE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic p0_valid_i,
  input  logic p1_valid_i,
  output logic p0_ready_o,
  output logic p1_ready_o
);

  localparam int unsigned SW = (STARVE > 0) ? $clog2(STARVE + 1) : 1;

  logic [SW-1:0] starve_q, starve_d;
  logic          gnt0, gnt1;

  always_comb begin
    gnt1       = p1_valid_i & (~p0_valid_i | (starve_q == SW'(STARVE)));
    gnt0       = p0_valid_i & ~gnt1;
    p0_ready_o = en_i & gnt0;
    p1_ready_o = en_i & gnt1;
    starve_d   = starve_q;
    if (p1_ready_o) begin
      starve_d = '0;
    end else if (p0_ready_o && p1_valid_i && (starve_q != SW'(STARVE))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end

endmodule

// File: rtl/jt12_wr_sched.sv
// Serialises register writes from a streamer and a CPU port onto the
// jt12_mmr write bus, skipping address phases that repeat the cached one.
module jt12_wr_sched #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned STARVE  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       p0_valid,
  input  logic       p0_part,
  input  logic [7:0] p0_reg,
  input  logic [7:0] p0_data,
  output logic       p0_ready,
  input  logic       p1_valid,
  input  logic       p1_part,
  input  logic [7:0] p1_reg,
  input  logic [7:0] p1_data,
  output logic       p1_ready,
  output logic       write,
  output logic [1:0] addr,
  output logic [7:0] din,
  input  logic       busy,
  output logic       timeout_err
);
  import jt12_wr_pkg::*;

  localparam int unsigned WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  wr_state_e      state_q;
  logic           part_q;
  logic [7:0]     reg_q, data_q;
  logic           cache_vld_q;
  logic [8:0]     cache_key_q;
  logic [WDW-1:0] wdog_q;
  logic           err_q, write_q;
  logic [1:0]     addr_q;
  logic [7:0]     din_q;

  logic           arb_en, acc, req_part, req_hit;
  logic [7:0]     req_reg, req_data;

  assign arb_en = (state_q == IDLE);

  jt12_wr_arb #(
    .STARVE(STARVE)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (arb_en),
    .p0_valid_i(p0_valid),
    .p1_valid_i(p1_valid),
    .p0_ready_o(p0_ready),
    .p1_ready_o(p1_ready)
  );

  always_comb begin
    acc      = (p0_valid & p0_ready) | (p1_valid & p1_ready);
    req_part = p1_ready ? p1_part : p0_part;
    req_reg  = p1_ready ? p1_reg  : p0_reg;
    req_data = p1_ready ? p1_data : p0_data;
    req_hit  = cache_vld_q && (cache_key_q == {req_part, req_reg});
  end

  // Bus outputs are loaded on the transition into ADDR/GAP->DATA so they are
  // registered yet line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      part_q      <= 1'b0;
      reg_q       <= '0;
      data_q      <= '0;
      cache_vld_q <= 1'b0;
      cache_key_q <= '0;
      wdog_q      <= '0;
      err_q       <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
    end else begin
      write_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (acc) begin
            part_q  <= req_part;
            reg_q   <= req_reg;
            data_q  <= req_data;
            write_q <= 1'b1;
            if (req_hit) begin
              state_q <= DATA;
              addr_q  <= {req_part, 1'b1};
              din_q   <= req_data;
            end else begin
              state_q <= ADDR;
              addr_q  <= {req_part, 1'b0};
              din_q   <= req_reg;
            end
          end
        end
        ADDR: begin
          cache_key_q <= {part_q, reg_q};
          cache_vld_q <= 1'b1;
          state_q     <= GAP;
        end
        GAP: begin
          write_q <= 1'b1;
          addr_q  <= {part_q, 1'b1};
          din_q   <= data_q;
          state_q <= DATA;
        end
        DATA: begin
          wdog_q <= '0;
          if (is_prescaler(reg_q)) cache_vld_q <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (!busy) begin
            state_q <= IDLE;
          end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign write       = write_q;
  assign addr        = addr_q;
  assign din         = din_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_jt12_wr_sched.sv
// Randomised self-checking bench for jt12_wr_sched with a behavioural
// register-cache / timing model and a simple jt12_mmr busy model.
module tb_jt12_wr_sched;

  localparam int unsigned TO = 15;
  localparam int unsigned SV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       p0_valid, p0_part, p1_valid, p1_part;
  logic [7:0] p0_reg, p0_data, p1_reg, p1_data;
  logic       p0_ready, p1_ready, write, busy, timeout_err;
  logic [1:0] addr;
  logic [7:0] din;

  always #5 clk = ~clk;

  jt12_wr_sched #(
    .TIMEOUT(TO),
    .STARVE (SV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .p0_valid   (p0_valid),
    .p0_part    (p0_part),
    .p0_reg     (p0_reg),
    .p0_data    (p0_data),
    .p0_ready   (p0_ready),
    .p1_valid   (p1_valid),
    .p1_part    (p1_part),
    .p1_reg     (p1_reg),
    .p1_data    (p1_data),
    .p1_ready   (p1_ready),
    .write      (write),
    .addr       (addr),
    .din        (din),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // jt12_mmr busy: high for busy_len cycles after a data-phase write.
  int   busy_len = 2;
  int   bcnt;
  logic stuck = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   bcnt <= 0;
    else if (write && addr[0])    bcnt <= busy_len;
    else if (bcnt != 0)           bcnt <= bcnt - 1;
  end
  assign busy = stuck | (bcnt != 0);

  typedef struct { int c; logic [1:0] a; logic [7:0] d; } ev_t;
  typedef struct { int c; int p; } acc_t;
  ev_t  bus_q[$];
  ev_t  exp_q[$];
  acc_t acc_q[$];
  int   exp_acc[8];
  int   dbl_wr = 0;
  logic prev_wr = 1'b0;

  always @(negedge clk) begin
    if (write) bus_q.push_back('{cyc, addr, din});
    if (write && prev_wr) dbl_wr <= dbl_wr + 1;
    prev_wr <= write;
    if (p0_valid && p0_ready) acc_q.push_back('{cyc, 0});
    if (p1_valid && p1_ready) acc_q.push_back('{cyc, 1});
  end

  // Reference model: address cache seen from the register map's side.
  bit         m_vld;
  logic [8:0] m_key;
  logic       sp[8];
  logic [7:0] sr[8], sd[8];
  logic [7:0] regs[8] = '{8'h2A, 8'h2A, 8'h2A, 8'h28, 8'h2D, 8'h2E, 8'h2F, 8'hB4};

  task automatic model_write(input logic pt, input logic [7:0] r, output bit hit);
    hit   = m_vld && (m_key == {pt, r});
    m_vld = 1'b1;
    m_key = {pt, r};
    if (r >= 8'h2D && r <= 8'h2F) m_vld = 1'b0;
  endtask

  task automatic build_exp(input int n, input int bl);
    bit hit;
    int t;
    exp_q.delete();
    t = (acc_q.size() > 0) ? acc_q[0].c : 0;
    for (int k = 0; k < n; k++) begin
      exp_acc[k] = t;
      model_write(sp[k], sr[k], hit);
      if (hit) begin
        exp_q.push_back('{t + 1, {sp[k], 1'b1}, sd[k]});
        t += 3 + bl;
      end else begin
        exp_q.push_back('{t + 1, {sp[k], 1'b0}, sr[k]});
        exp_q.push_back('{t + 3, {sp[k], 1'b1}, sd[k]});
        t += 5 + bl;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int port, input logic pt, input logic [7:0] r,
                         input logic [7:0] d, input logic v);
    if (port == 0) begin
      p0_valid = v; p0_part = pt; p0_reg = r; p0_data = d;
    end else begin
      p1_valid = v; p1_part = pt; p1_reg = r; p1_data = d;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_req(0, 1'b0, 8'h00, 8'h00, 1'b0);
    set_req(1, 1'b0, 8'h00, 8'h00, 1'b0);
    stuck = 1'b0;
    m_vld = 1'b0;
    m_key = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Hold one port valid and present sp/sr/sd[0..n-1] back to back.
  task automatic run_stream(input int port, input int n, input int bl);
    bus_q.delete();
    acc_q.delete();
    busy_len = bl;
    @(posedge clk);
    #1;
    set_req(port, sp[0], sr[0], sd[0], 1'b1);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 400 && acc_q.size() <= k; i++) tick();
      if (acc_q.size() <= k) begin
        n_tot++;
        $display("FAIL accept_wait: port %0d request %0d got no acceptance in 400 cycles", port, k);
        break;
      end
      @(posedge clk);
      #1;
      if (k + 1 < n) set_req(port, sp[k+1], sr[k+1], sd[k+1], 1'b1);
    end
    set_req(port, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (10 + bl) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_req(0, 1'b0, 8'h00, 8'h00, 1'b0);
    set_req(1, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (2) tick();
    n_tot++;
    if ({write, addr, din} !== 11'd0) $display("FAIL reset_bus: write/addr/din=%b, required 0", {write, addr, din});
    else n_pass++;
    n_tot++;
    if ({p0_ready, p1_ready, timeout_err} !== 3'b000) $display("FAIL reset_flags: ready0/ready1/err=%b, required 000", {p0_ready, p1_ready, timeout_err});
    else n_pass++;
    rst_n = 1'b1;
    repeat (2) tick();
    n_tot++;
    if (write !== 1'b0) $display("FAIL reset_idle_write: write=%b, required 0", write);
    else n_pass++;
  endtask

  task automatic test_cold_write();
    int bl, t;
    do_reset();
    bl = $urandom_range(1, 6);
    sp[0] = 1'b0; sr[0] = 8'h28; sd[0] = 8'hF0;
    sp[1] = 1'b0; sr[1] = 8'h28; sd[1] = 8'($urandom);
    run_stream(1, 2, bl);
    t = (acc_q.size() > 0) ? acc_q[0].c : -100;
    n_tot++;
    if (bus_q.size() !== 3) $display("FAIL cold_count: %0d write pulses, required 3", bus_q.size());
    else n_pass++;
    if (bus_q.size() == 3) begin
      n_tot++;
      if ({bus_q[0].c - t, bus_q[0].a, bus_q[0].d} !== {32'd1, 2'd0, 8'h28})
        $display("FAIL cold_addr: T+%0d addr=%0d din=%h, required T+1 addr=0 din=28", bus_q[0].c - t, bus_q[0].a, bus_q[0].d);
      else n_pass++;
      n_tot++;
      if ({bus_q[1].c - t, bus_q[1].a, bus_q[1].d} !== {32'd3, 2'd1, 8'hF0})
        $display("FAIL cold_data: T+%0d addr=%0d din=%h, required T+3 addr=1 din=F0", bus_q[1].c - t, bus_q[1].a, bus_q[1].d);
      else n_pass++;
      n_tot++;
      if ({bus_q[2].c - t, bus_q[2].a, bus_q[2].d} !== {32'(6 + bl), 2'd1, sd[1]})
        $display("FAIL cold_second: T+%0d addr=%0d din=%h, required T+%0d addr=1 din=%h", bus_q[2].c - t, bus_q[2].a, bus_q[2].d, 6 + bl, sd[1]);
      else n_pass++;
    end
    n_tot++;
    if (acc_q.size() < 2 || acc_q[1].c - t !== 5 + bl)
      $display("FAIL cold_ready_hold: next acceptance at T+%0d, required T+%0d", (acc_q.size() < 2) ? -1 : acc_q[1].c - t, 5 + bl);
    else n_pass++;
    model_write(1'b0, 8'h28, m_vld);
    m_vld = 1'b1;
  endtask

  task automatic test_addr_skip();
    int  bl, got;
    ev_t g;
    do_reset();
    bl = $urandom_range(1, 6);
    for (int k = 0; k < 3; k++) begin
      sp[k] = 1'b0; sr[k] = 8'h2A; sd[k] = 8'h80 + 8'(k);
    end
    run_stream(0, 3, bl);
    build_exp(3, bl);
    for (int k = 1; k < 3; k++) begin
      got = (k < acc_q.size()) ? acc_q[k].c : -1;
      n_tot++;
      if (got !== exp_acc[k]) $display("FAIL skip_accept[%0d]: cycle %0d, required %0d", k, got, exp_acc[k]);
      else n_pass++;
    end
    n_tot++;
    if (bus_q.size() !== exp_q.size()) $display("FAIL skip_count: %0d pulses, required %0d", bus_q.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < bus_q.size()) g = bus_q[k]; else g = '{-1, 2'd0, 8'd0};
      n_tot++;
      if (g.c !== exp_q[k].c || g.a !== exp_q[k].a || g.d !== exp_q[k].d)
        $display("FAIL skip_ev[%0d]: c=%0d a=%0d d=%h, required c=%0d a=%0d d=%h", k, g.c, g.a, g.d, exp_q[k].c, exp_q[k].a, exp_q[k].d);
      else n_pass++;
    end
  endtask

  task automatic test_cache_inval();
    int  bl;
    ev_t g;
    bl = $urandom_range(1, 4);
    sp[0] = 1'b0; sr[0] = 8'h2D; sd[0] = 8'($urandom);
    sp[1] = 1'b0; sr[1] = 8'h2D; sd[1] = 8'($urandom);
    sp[2] = 1'b0; sr[2] = 8'h28; sd[2] = 8'($urandom);
    sp[3] = 1'b1; sr[3] = 8'h28; sd[3] = 8'($urandom);
    sp[4] = 1'b1; sr[4] = 8'h28; sd[4] = 8'($urandom);
    run_stream(1, 5, bl);
    build_exp(5, bl);
    n_tot++;
    if (bus_q.size() !== exp_q.size()) $display("FAIL inval_count: %0d pulses, required %0d", bus_q.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < bus_q.size()) g = bus_q[k]; else g = '{-1, 2'd0, 8'd0};
      n_tot++;
      if (g.c !== exp_q[k].c || g.a !== exp_q[k].a || g.d !== exp_q[k].d)
        $display("FAIL inval_ev[%0d]: c=%0d a=%0d d=%h, required c=%0d a=%0d d=%h", k, g.c, g.a, g.d, exp_q[k].c, exp_q[k].a, exp_q[k].d);
      else n_pass++;
    end
  endtask

  task automatic test_random_mix();
    for (int r = 0; r < 8; r++) begin
      int  port, n, bl, got;
      ev_t g;
      port = $urandom_range(0, 1);
      n    = $urandom_range(1, 4);
      bl   = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        sp[k] = ($urandom_range(0, 3) == 0);
        sr[k] = regs[$urandom_range(0, 7)];
        sd[k] = 8'($urandom);
      end
      run_stream(port, n, bl);
      build_exp(n, bl);
      for (int k = 1; k < n; k++) begin
        got = (k < acc_q.size()) ? acc_q[k].c : -1;
        n_tot++;
        if (got !== exp_acc[k]) $display("FAIL mix_accept[%0d.%0d]: cycle %0d, required %0d", r, k, got, exp_acc[k]);
        else n_pass++;
      end
      n_tot++;
      if (bus_q.size() !== exp_q.size()) $display("FAIL mix_count[%0d]: %0d pulses, required %0d", r, bus_q.size(), exp_q.size());
      else n_pass++;
      for (int k = 0; k < exp_q.size(); k++) begin
        if (k < bus_q.size()) g = bus_q[k]; else g = '{-1, 2'd0, 8'd0};
        n_tot++;
        if (g.c !== exp_q[k].c || g.a !== exp_q[k].a || g.d !== exp_q[k].d)
          $display("FAIL mix_ev[%0d.%0d]: c=%0d a=%0d d=%h, required c=%0d a=%0d d=%h", r, k, g.c, g.a, g.d, exp_q[k].c, exp_q[k].a, exp_q[k].d);
        else n_pass++;
      end
    end
  endtask

  task automatic test_starvation();
    int sc, ex;
    do_reset();
    busy_len = 1;
    acc_q.delete();
    set_req(0, 1'b0, 8'h2A, 8'h11, 1'b1);
    set_req(1, 1'b0, 8'h28, 8'h22, 1'b1);
    for (int i = 0; i < 1000 && acc_q.size() < 12; i++) tick();
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 8'h00, 8'h00, 1'b0);
    set_req(1, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (12) tick();
    sc = 0;
    for (int k = 0; k < 12; k++) begin
      if (sc == SV) begin ex = 1; sc = 0; end
      else begin ex = 0; sc++; end
      n_tot++;
      if (k >= acc_q.size()) $display("FAIL starve_grant[%0d]: no grant, required port %0d", k, ex);
      else if (acc_q[k].p !== ex) $display("FAIL starve_grant[%0d]: port %0d, required port %0d", k, acc_q[k].p, ex);
      else n_pass++;
    end
  endtask

  task automatic test_watchdog();
    int t;
    bit h;
    do_reset();
    stuck = 1'b1;
    acc_q.delete();
    set_req(1, 1'b0, 8'h28, 8'h55, 1'b1);
    for (int i = 0; i < 50 && acc_q.size() == 0; i++) tick();
    if (acc_q.size() == 0) begin
      n_tot++;
      $display("FAIL wdog_accept: no acceptance in 50 cycles, required one");
      set_req(1, 1'b0, 8'h00, 8'h00, 1'b0);
      stuck = 1'b0;
      return;
    end
    t = acc_q[0].c;
    model_write(1'b0, 8'h28, h);
    @(posedge clk);
    #1;
    set_req(1, 1'b0, 8'h28, 8'h56, 1'b1);
    for (int i = 0; i < 100 && acc_q.size() < 2; i++) begin
      tick();
      if (cyc == t + 3 + int'(TO)) begin
        n_tot++;
        if (timeout_err !== 1'b0) $display("FAIL wdog_early: timeout_err=%b in last wait cycle, required 0", timeout_err);
        else n_pass++;
      end
    end
    n_tot++;
    if (acc_q.size() < 2 || acc_q[1].c !== t + 4 + int'(TO))
      $display("FAIL wdog_return: next acceptance at T+%0d, required T+%0d", (acc_q.size() < 2) ? -1 : acc_q[1].c - t, 4 + TO);
    else n_pass++;
    n_tot++;
    if (timeout_err !== 1'b1) $display("FAIL wdog_flag: timeout_err=%b, required 1", timeout_err);
    else n_pass++;
    model_write(1'b0, 8'h28, h);
    @(posedge clk);
    #1;
    set_req(1, 1'b0, 8'h00, 8'h00, 1'b0);
    stuck = 1'b0;
    busy_len = 2;
    repeat (15) tick();
    n_tot++;
    if (timeout_err !== 1'b1) $display("FAIL wdog_sticky: timeout_err=%b, required 1", timeout_err);
    else n_pass++;
  endtask

  task automatic test_midop_reset();
    int  t, tdata, bl;
    bit  h;
    ev_t g;
    acc_q.delete();
    busy_len = 2;
    @(posedge clk);
    #1;
    set_req(0, 1'b0, 8'h28, 8'h77, 1'b1);
    for (int i = 0; i < 50 && acc_q.size() == 0; i++) tick();
    if (acc_q.size() == 0) begin
      n_tot++;
      $display("FAIL midrst_accept: no acceptance in 50 cycles, required one");
    end else begin
      t = acc_q[0].c;
      model_write(1'b0, 8'h28, h);
      tdata = h ? t + 1 : t + 3;
      @(posedge clk);
      #1;
      set_req(0, 1'b0, 8'h00, 8'h00, 1'b0);
      for (int i = 0; i < 10 && cyc < tdata; i++) tick();
      n_tot++;
      if (write !== 1'b1) $display("FAIL midrst_data: write=%b in data phase, required 1", write);
      else n_pass++;
    end
    rst_n = 1'b0;
    m_vld = 1'b0;
    #1;
    n_tot++;
    if (write !== 1'b0) $display("FAIL midrst_async: write=%b during reset, required 0", write);
    else n_pass++;
    n_tot++;
    if (timeout_err !== 1'b0) $display("FAIL midrst_err: timeout_err=%b during reset, required 0", timeout_err);
    else n_pass++;
    repeat (2) tick();
    rst_n = 1'b1;
    bl = $urandom_range(1, 4);
    sp[0] = 1'b0; sr[0] = 8'h28; sd[0] = 8'h78;
    run_stream(0, 1, bl);
    build_exp(1, bl);
    n_tot++;
    if (bus_q.size() !== exp_q.size()) $display("FAIL midrst_count: %0d pulses, required %0d", bus_q.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < bus_q.size()) g = bus_q[k]; else g = '{-1, 2'd0, 8'd0};
      n_tot++;
      if (g.c !== exp_q[k].c || g.a !== exp_q[k].a || g.d !== exp_q[k].d)
        $display("FAIL midrst_ev[%0d]: c=%0d a=%0d d=%h, required c=%0d a=%0d d=%h", k, g.c, g.a, g.d, exp_q[k].c, exp_q[k].a, exp_q[k].d);
      else n_pass++;
    end
  endtask

  task automatic test_no_double_write();
    n_tot++;
    if (dbl_wr !== 0) $display("FAIL write_spacing: %0d back-to-back write cycles, required 0", dbl_wr);
    else n_pass++;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: bench did not finish in time");
    $display("%0d/%0d checks passed", n_pass, n_tot + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cold_write();
    test_addr_skip();
    test_cache_inval();
    test_random_mix();
    test_starvation();
    test_watchdog();
    test_midop_reset();
    test_no_double_write();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
